// File: rtl/pmem_arb_pkg.sv
// Shared types and default widths for the I/D physical-memory arbiter.
package pmem_arb_pkg;

  localparam int PMEM_ADDR_W = 16;
  localparam int PMEM_LINE_W = 256;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side
// that was not granted last.
module arb_rr_pick
  import pmem_arb_pkg::*;
(
  input  logic   i_req_i,
  input  logic   i_req_d,
  input  grant_t i_last_grant,
  output grant_t o_grant,
  output logic   o_any
);

  always_comb begin
    o_any   = i_req_i | i_req_d;
    o_grant = GRANT_I;
    if (i_req_i && i_req_d) begin
      o_grant = (i_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (i_req_d) begin
      o_grant = GRANT_D;
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Merges the I-cache and D-cache line ports onto one physical-memory port,
// one transaction at a time, with fields captured at grant.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W = PMEM_ADDR_W,
  parameter int LINE_W = PMEM_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  grant_t            r_last_grant;
  grant_t            w_grant;
  logic              w_any;
  logic              w_d_req;
  logic              w_take;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_op_write;

  assign w_d_req = d_pmem_read | d_pmem_write;
  assign w_take  = (r_state == IDLE) && w_any;

  arb_rr_pick u_pick (
    .i_req_i      (i_pmem_read),
    .i_req_d      (w_d_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any        (w_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Strobes and responses decode from state alone, so reset drops them at once.
  always_comb begin
    w_state_next = r_state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next = (w_grant == GRANT_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        pmem_read   = ~r_op_write;
        pmem_write  = r_op_write;
        i_pmem_resp = pmem_resp;
        if (pmem_resp) w_state_next = IDLE;
      end
      SERVE_D: begin
        pmem_read   = ~r_op_write;
        pmem_write  = r_op_write;
        d_pmem_resp = pmem_resp;
        if (pmem_resp) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A D request with both read and write high is treated as a write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= GRANT_I;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_op_write   <= 1'b0;
    end else if (w_take) begin
      r_last_grant <= w_grant;
      if (w_grant == GRANT_D) begin
        r_addr     <= d_pmem_address;
        r_wdata    <= d_pmem_wdata;
        r_op_write <= d_pmem_write;
      end else begin
        r_addr     <= i_pmem_address;
        r_op_write <= 1'b0;
      end
    end
  end

  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed scenarios plus randomized cache/memory traffic, checked every
// cycle against a transaction-level arbitration model.
module tb_pmem_arbiter;
  import pmem_arb_pkg::*;

  localparam int AW = 16;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int vectors     = 0;
  int miscompares = 0;

  pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 0 = nobody, 1 = I, 2 = D. One transaction at a time,
  // fields frozen when the owner is chosen, owner released on memory resp.
  int            m_own;
  int            m_last;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_pmem_read", LW'(pmem_read), LW'(0));
      chk("rst_pmem_write", LW'(pmem_write), LW'(0));
      chk("rst_i_resp", LW'(i_pmem_resp), LW'(0));
      chk("rst_d_resp", LW'(d_pmem_resp), LW'(0));
      chk("rst_pmem_address", LW'(pmem_address), LW'(0));
      chk("rst_pmem_wdata", pmem_wdata, LW'(0));
      m_own = 0; m_last = 1; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    end else begin
      chk("m_pmem_read", LW'(pmem_read), LW'((m_own != 0) && !m_wr));
      chk("m_pmem_write", LW'(pmem_write), LW'((m_own != 0) && m_wr));
      chk("m_i_resp", LW'(i_pmem_resp), LW'((m_own == 1) && pmem_resp));
      chk("m_d_resp", LW'(d_pmem_resp), LW'((m_own == 2) && pmem_resp));
      chk("m_pmem_address", LW'(pmem_address), LW'(m_addr));
      chk("m_i_rdata", i_pmem_rdata, pmem_rdata);
      chk("m_d_rdata", d_pmem_rdata, pmem_rdata);
      if (m_own != 0 && m_wr) chk("m_pmem_wdata", pmem_wdata, m_wdata);
      if (m_own != 0) begin
        if (pmem_resp) m_own = 0;
      end else begin
        bit ir, dr;
        ir = i_pmem_read;
        dr = d_pmem_read || d_pmem_write;
        if (ir && dr) m_own = (m_last == 1) ? 2 : 1;
        else if (ir)  m_own = 1;
        else if (dr)  m_own = 2;
        if (m_own == 1) begin
          m_last = 1; m_addr = i_pmem_address; m_wr = 1'b0;
        end else if (m_own == 2) begin
          m_last = 2; m_addr = d_pmem_address; m_wr = d_pmem_write; m_wdata = d_pmem_wdata;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Serve the currently granted transaction for lat+1 cycles with literal checks;
  // returns in the following idle cycle with that side's request dropped.
  task automatic serve(input int side, input logic [AW-1:0] addr, input bit wr,
                       input logic [LW-1:0] wd, input int lat, input logic [LW-1:0] rdv,
                       input bit mangle);
    for (int k = 0; k <= lat; k++) begin
      pmem_rdata = (k == lat) ? rdv : {8{$urandom}};
      pmem_resp  = (k == lat);
      if (mangle && k == 1) begin
        if (side == 2) begin
          d_pmem_address = 16'hFFFF;
          d_pmem_wdata   = ~wd;
        end else begin
          i_pmem_address = 16'hFFFF;
        end
      end
      #1;
      chk("dir_read", LW'(pmem_read), LW'(!wr));
      chk("dir_write", LW'(pmem_write), LW'(wr));
      chk("dir_address", LW'(pmem_address), LW'(addr));
      if (wr) chk("dir_wdata", pmem_wdata, wd);
      if (k == lat) begin
        chk("dir_i_resp", LW'(i_pmem_resp), LW'(side == 1));
        chk("dir_d_resp", LW'(d_pmem_resp), LW'(side == 2));
        chk("dir_rdata", (side == 1) ? i_pmem_rdata : d_pmem_rdata, rdv);
      end
      cyc();
    end
    pmem_resp = 1'b0;
    if (side == 1) i_pmem_read = 1'b0;
    else begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
  endtask

  logic [LW-1:0] dead_line;
  logic [LW-1:0] a5_line;
  bit            i_seen, d_seen;
  int            mem_cnt, mem_lat;

  initial begin
    dead_line = {16{16'hDEAD}};
    a5_line   = {32{8'hA5}};
    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // Lone I fill, memory answers in the fifth strobe cycle.
    i_pmem_read = 1'b1; i_pmem_address = 16'h1240;
    cyc();
    serve(1, 16'h1240, 1'b0, '0, 4, a5_line, 1'b0);
    #1 chk("i_fill_release", LW'(pmem_read), LW'(0));
    cyc();

    // Reset in the middle of a D service, with memory resp high.
    d_pmem_read = 1'b1; d_pmem_address = 16'h0777;
    cyc();
    pmem_resp = 1'b1;
    #1 chk("pre_rst_read", LW'(pmem_read), LW'(1));
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_read", LW'(pmem_read), LW'(0));
    chk("mid_rst_write", LW'(pmem_write), LW'(0));
    chk("mid_rst_d_resp", LW'(d_pmem_resp), LW'(0));
    chk("mid_rst_i_resp", LW'(i_pmem_resp), LW'(0));
    pmem_resp = 1'b0; d_pmem_read = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    #1 chk("post_rst_idle", LW'(pmem_read | pmem_write), LW'(0));

    // Simultaneous requests after reset: D first, I after one idle cycle.
    i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2200;
    cyc();
    serve(2, 16'h2200, 1'b0, '0, 3, {8{32'h1234_5678}}, 1'b1);
    #1 chk("tie_gap_idle", LW'(pmem_read | pmem_write), LW'(0));
    cyc();
    serve(1, 16'h0100, 1'b0, '0, 1, {8{32'h0BAD_F00D}}, 1'b0);
    cyc();

    // D write-back, then I (pending) ahead of the D fill.
    d_pmem_write = 1'b1; d_pmem_address = 16'h3300; d_pmem_wdata = dead_line;
    cyc();
    i_pmem_read = 1'b1; i_pmem_address = 16'h0500;
    serve(2, 16'h3300, 1'b1, dead_line, 3, {8{32'h0}}, 1'b1);
    d_pmem_read = 1'b1; d_pmem_address = 16'h4400;
    #1 chk("wb_gap_idle", LW'(pmem_read | pmem_write), LW'(0));
    cyc();
    serve(1, 16'h0500, 1'b0, '0, 2, {8{32'hCAFE_0001}}, 1'b0);
    cyc();
    serve(2, 16'h4400, 1'b0, '0, 1, {8{32'hCAFE_0002}}, 1'b0);

    // Stray memory resp while idle.
    pmem_resp = 1'b1;
    #1;
    chk("stray_i_resp", LW'(i_pmem_resp), LW'(0));
    chk("stray_d_resp", LW'(d_pmem_resp), LW'(0));
    cyc();
    pmem_resp = 1'b0;
    #1 chk("stray_no_strobe", LW'(pmem_read | pmem_write), LW'(0));

    // Randomized traffic.
    i_seen = 1'b0; d_seen = 1'b0; mem_cnt = 0; mem_lat = 2;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      pmem_rdata = {8{$urandom}};
      if (pmem_read || pmem_write) begin
        if (mem_cnt >= mem_lat) begin
          pmem_resp = 1'b1; mem_cnt = 0; mem_lat = $urandom_range(0, 4);
        end else begin
          pmem_resp = 1'b0; mem_cnt++;
        end
      end else begin
        pmem_resp = ($urandom_range(0, 9) == 0); mem_cnt = 0;
      end
      if (i_seen) i_pmem_read = 1'b0;
      if (!i_pmem_read) begin
        if ($urandom_range(0, 2) == 0) begin
          i_pmem_read = 1'b1; i_pmem_address = AW'($urandom);
        end
      end else begin
        if ($urandom_range(0, 7) == 0) i_pmem_address = AW'($urandom);
        if ($urandom_range(0, 15) == 0) i_pmem_read = 1'b0;
      end
      if (d_seen) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
      if (!(d_pmem_read || d_pmem_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          bit op;
          op = 1'($urandom_range(0, 1));
          d_pmem_read = !op; d_pmem_write = op;
          d_pmem_address = AW'($urandom); d_pmem_wdata = {8{$urandom}};
        end
      end else begin
        if ($urandom_range(0, 7) == 0) begin
          d_pmem_address = AW'($urandom); d_pmem_wdata = {8{$urandom}};
        end
        if ($urandom_range(0, 15) == 0) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
      end
      #3;
      i_seen = i_pmem_resp;
      d_seen = d_pmem_resp;
    end

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
